// File: rtl/nr_mul_acc.sv
// Sequential shift-add multiply-accumulate: p_out = q*m + r, one multiplier bit per clock.
// Optional result checker against an expected value when NR_MUL_ACC_CHECK_EN is defined.
module nr_mul_acc #(
   parameter int unsigned WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     q_in,
   input  logic [WIDTH-1:0]     m_in,
   input  logic [WIDTH-1:0]     r_in,
   output logic                 p_valid,
   input  logic                 p_ready,
   output logic [2*WIDTH-1:0]   p_out,
   output logic                 busy
`ifdef NR_MUL_ACC_CHECK_EN
   ,
   input  logic [2*WIDTH-1:0]   exp_in,
   output logic                 mismatch
`endif
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [WIDTH-1:0] m_reg, m_nxt;
   logic [WIDTH:0]   acc_hi, acc_nxt;
   logic [WIDTH-1:0] mq, mq_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [PW-1:0]    p_out_nxt;
   logic             in_ready_nxt, p_valid_nxt, busy_nxt;
   logic [WIDTH:0]   sum;
`ifdef NR_MUL_ACC_CHECK_EN
   logic [PW-1:0]    exp_reg, exp_nxt;
   logic             mismatch_nxt;
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         m_reg    <= '0;
         acc_hi   <= '0;
         mq       <= '0;
         cnt      <= '0;
         p_out    <= '0;
         in_ready <= 1'b1;
         p_valid  <= 1'b0;
         busy     <= 1'b0;
`ifdef NR_MUL_ACC_CHECK_EN
         exp_reg  <= '0;
         mismatch <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         m_reg    <= m_nxt;
         acc_hi   <= acc_nxt;
         mq       <= mq_nxt;
         cnt      <= cnt_nxt;
         p_out    <= p_out_nxt;
         in_ready <= in_ready_nxt;
         p_valid  <= p_valid_nxt;
         busy     <= busy_nxt;
`ifdef NR_MUL_ACC_CHECK_EN
         exp_reg  <= exp_nxt;
         mismatch <= mismatch_nxt;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt    = state;
      m_nxt        = m_reg;
      acc_nxt      = acc_hi;
      mq_nxt       = mq;
      cnt_nxt      = cnt;
      p_out_nxt    = p_out;
      in_ready_nxt = in_ready;
      p_valid_nxt  = p_valid;
      busy_nxt     = busy;
`ifdef NR_MUL_ACC_CHECK_EN
      exp_nxt      = exp_reg;
      mismatch_nxt = mismatch;
`endif
      // acc_hi never exceeds 2^WIDTH-1 between steps, so WIDTH+1 bits cannot overflow
      sum = acc_hi + (mq[0] ? {1'b0, m_reg} : '0);

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt    = ST_RUN;
               m_nxt        = m_in;
               acc_nxt      = {1'b0, r_in};
               mq_nxt       = q_in;
               cnt_nxt      = '0;
               in_ready_nxt = 1'b0;
               busy_nxt     = 1'b1;
`ifdef NR_MUL_ACC_CHECK_EN
               exp_nxt      = exp_in;
`endif
            end
         end
         ST_RUN: begin
            acc_nxt = {1'b0, sum[WIDTH:1]};
            mq_nxt  = {sum[0], mq[WIDTH-1:1]};
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
               state_nxt   = ST_DONE;
               busy_nxt    = 1'b0;
               p_valid_nxt = 1'b1;
               p_out_nxt   = {sum, mq[WIDTH-1:1]};
`ifdef NR_MUL_ACC_CHECK_EN
               mismatch_nxt = ({sum, mq[WIDTH-1:1]} != exp_reg);
`endif
            end
         end
         ST_DONE: begin
            if (p_ready) begin
               state_nxt    = ST_IDLE;
               p_valid_nxt  = 1'b0;
               in_ready_nxt = 1'b1;
`ifdef NR_MUL_ACC_CHECK_EN
               mismatch_nxt = 1'b0;
`endif
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            in_ready_nxt = 1'b1;
            p_valid_nxt  = 1'b0;
            busy_nxt     = 1'b0;
`ifdef NR_MUL_ACC_CHECK_EN
            mismatch_nxt = 1'b0;
`endif
         end
      endcase
   end

endmodule

// File: tb/tb_nr_mul_acc.sv
// Scoreboard bench for nr_mul_acc: expected results queued at launch, compared at the output handshake.
module tb_nr_mul_acc;

   localparam int unsigned W = 24;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           p_ready = 1'b0;
   logic [W-1:0]   q_in = '0;
   logic [W-1:0]   m_in = '0;
   logic [W-1:0]   r_in = '0;
   logic           in_ready;
   logic           p_valid;
   logic           busy;
   logic [2*W-1:0] p_out;
`ifdef NR_MUL_ACC_CHECK_EN
   logic [2*W-1:0] exp_in = '0;
   logic           mismatch;
   logic           sb_mm[$];
`endif

   logic [2*W-1:0] sb[$];
   int             checks = 0;
   int             failures = 0;
   int unsigned    cyc = 0;
   int unsigned    t_acc = 0;

   nr_mul_acc #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_ready (in_ready),
      .q_in     (q_in),
      .m_in     (m_in),
      .r_in     (r_in),
      .p_valid  (p_valid),
      .p_ready  (p_ready),
      .p_out    (p_out),
      .busy     (busy)
`ifdef NR_MUL_ACC_CHECK_EN
      ,
      .exp_in   (exp_in),
      .mismatch (mismatch)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Stimulus is driven 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] q, input logic [W-1:0] m,
                                            input logic [W-1:0] r);
      return (2*W)'(q) * (2*W)'(m) + (2*W)'(r);
   endfunction

   task automatic launch(input logic [W-1:0] q, input logic [W-1:0] m, input logic [W-1:0] r,
                         input logic [2*W-1:0] p_exp, input logic [2*W-1:0] exp_drive);
      int n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) check("launch_timeout", 64'(in_ready), 64'd1);
      q_in = q;
      m_in = m;
      r_in = r;
`ifdef NR_MUL_ACC_CHECK_EN
      exp_in = exp_drive;
      sb_mm.push_back(exp_drive != p_exp);
`else
      if (exp_drive != p_exp) $display("note: expected-value input unused in this build");
`endif
      sb.push_back(p_exp);
      start = 1'b1;
      tick();
      t_acc = cyc;
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!p_valid && n < 100) begin
         tick();
         n++;
      end
      if (!p_valid) check("valid_timeout", 64'(p_valid), 64'd1);
   endtask

   // Output monitor: pops one expected result per accepted handshake
   always @(negedge clk) begin
      if (!rst && p_valid && p_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 64'(sb.size()), 64'd1);
         end else begin
            check("p_out", p_out, sb.pop_front());
`ifdef NR_MUL_ACC_CHECK_EN
            if (sb_mm.size() != 0) check("mismatch", 64'(mismatch), 64'(sb_mm.pop_front()));
`endif
         end
      end
`ifdef NR_MUL_ACC_CHECK_EN
      if (!rst && !p_valid) check("mismatch_idle", 64'(mismatch), 64'd0);
`endif
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2*W-1:0] exp_h;
      logic [W-1:0]   qa, ma, ra;
      logic [W-1:0]   bq[3];
      logic [W-1:0]   bm[3];
      logic [W-1:0]   br[3];
      int unsigned    acc_cyc[3];
      int             busy_cnt;
      int             n;
      int             i;

      // Reset state
      rst = 1'b1;
      p_ready = 1'b1;
      repeat (3) tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_p_valid", 64'(p_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_p_out", p_out, 64'd0);
      rst = 1'b0;
      tick();

      // Basic op: latency and busy duration
      launch(24'd3, 24'd5, 24'd2, 48'h000000000011, 48'h000000000011);
      busy_cnt = 0;
      n = 0;
      while (!p_valid && n < 100) begin
         if (busy) busy_cnt++;
         tick();
         n++;
      end
      check("latency", 64'(cyc - t_acc), 64'(W));
      check("busy_cycles", 64'(busy_cnt), 64'(W));
      drain();

      // Maximum and zero-multiplier cases
      launch(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFF000000, 48'hFFFFFF000000);
      drain();
      launch(24'h000000, 24'h123456, 24'h00ABCD, 48'h00000000ABCD, 48'h00000000ABCD);
      drain();

      // Backpressure hold; start and input changes during RUN and DONE are ignored
      p_ready = 1'b0;
      qa = 24'hA5A5A5;
      ma = 24'h3C3C3C;
      ra = 24'h00F00F;
      exp_h = model(qa, ma, ra);
      launch(qa, ma, ra, exp_h, exp_h);
      repeat (5) tick();
      q_in = 24'h111111;
      m_in = 24'h222222;
      r_in = 24'h333333;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid();
      for (int k = 0; k < 10; k++) begin
         check("hold_valid", 64'(p_valid), 64'd1);
         check("hold_p_out", p_out, exp_h);
         start = k[0];
         q_in = W'($urandom);
         tick();
      end
      start = 1'b1;
      p_ready = 1'b1;
      tick();
      check("hs_in_ready", 64'(in_ready), 64'd1);
      check("hs_p_valid", 64'(p_valid), 64'd0);
      start = 1'b0;
      tick();
      check("no_second_op", 64'(busy), 64'd0);
      check("p_out_kept", p_out, exp_h);

      // Asynchronous reset in the middle of RUN
      launch(24'h001234, 24'h005678, 24'h00009A, model(24'h001234, 24'h005678, 24'h00009A),
             model(24'h001234, 24'h005678, 24'h00009A));
      repeat (12) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_p_valid", 64'(p_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_p_out", p_out, 64'd0);
      sb.delete();
`ifdef NR_MUL_ACC_CHECK_EN
      sb_mm.delete();
`endif
      tick();
      rst = 1'b0;
      tick();
      launch(24'd7, 24'd9, 24'd0, 48'h00000000003F, 48'h00000000003F);
      drain();

      // Back-to-back with p_ready tied high
      bq[0] = 24'h000010; bm[0] = 24'h000020; br[0] = 24'h000001;
      bq[1] = 24'hFFFFFF; bm[1] = 24'h000001; br[1] = 24'hFFFFFF;
      bq[2] = 24'h800000; bm[2] = 24'h800000; br[2] = 24'h7FFFFF;
      i = 0;
      n = 0;
      while (i < 3 && n < 300) begin
         if (in_ready) begin
            q_in = bq[i];
            m_in = bm[i];
            r_in = br[i];
            sb.push_back(model(bq[i], bm[i], br[i]));
`ifdef NR_MUL_ACC_CHECK_EN
            exp_in = model(bq[i], bm[i], br[i]);
            sb_mm.push_back(1'b0);
`endif
            start = 1'b1;
            tick();
            acc_cyc[i] = cyc;
            i++;
         end else begin
            start = 1'b0;
            tick();
         end
         n++;
      end
      start = 1'b0;
      if (i < 3) check("b2b_timeout", 64'(i), 64'd3);
      check("b2b_spacing_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(W + 2));
      check("b2b_spacing_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(W + 2));
      drain();

      // Random operands
      for (int k = 0; k < 4; k++) begin
         qa = W'($urandom);
         ma = W'($urandom);
         ra = W'($urandom);
         launch(qa, ma, ra, model(qa, ma, ra), model(qa, ma, ra));
         drain();
      end

`ifdef NR_MUL_ACC_CHECK_EN
      // Dividend reconstruction check
      launch(24'h000100, 24'h000010, 24'h000005, 48'h000000001005, 48'h000000001005);
      drain();
      launch(24'h000100, 24'h000010, 24'h000005, 48'h000000001005, 48'h000000001006);
      drain();
`endif

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
